rnn_seq_engine: RTL and testbench
=================================

# rnn_seq_engine

Parametrised, memory-mapped single-layer Elman RNN step engine with a multi-channel dense output head. It time-multiplexes one signed multiply-accumulate unit across every input, recurrent and dense product. The hidden state is double-buffered and persists across steps until an explicit clear. It sits on the processor bus as a slave peripheral, as a drop-in successor to the fixed-size RNN accelerator, and adds:

- sizes set by parameters;
- hard-tanh activation;
- 2^OUT_BITS result channels;
- a completion interrupt.

## Interface
- EMB_BITS, 2, log2 of input vector length E.
- RNN_BITS, 5, log2 of hidden size N.
- OUT_BITS, 0, log2 of dense output channels C.
- FRAC_BITS, 8, fractional bits of the 16-bit signed fixed-point format.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset. The block has one clock, and reset is asynchronous and active-high.
- read  in  1  bus read strobe.
- write  in  1  bus write strobe.
- addr  in  3  register select.
- data_in  in  32  write data: [15:0] value, [23:16] column/index, [31:24] row/channel.
- data_out  out  32  read data, sign-extended 16-bit; 0 when read=0.
- irq  out  1  one-cycle pulse when a step or dense pass completes.

## Operation
- Write map. All writes except to addr 0 are ignored while busy.
  - 0 CTRL: bit0 starts a step, bit1 starts a dense pass, bit2 clears h.
  - 1 x[idx].
  - 2 Wx[row][col].
  - 3 Wh[row][col].
  - 4 b[idx].
  - 5 Wd[ch][idx].
  - 6 bd[ch].
  - 7 sets rptr = data_in[31:24].
- Read map:
  - 0 STATUS {valid, busy} in bits [1:0].
  - 1 step count (16-bit, wraps).
  - 2 h[data_in[23:16]].
  - 7 result[rptr]; rptr increments on each read cycle and wraps mod C. Reading channel C-1 clears valid.
  - Others read 0.
- Index fields wider than their array are truncated to the low bits.
- Product: 32-bit signed a*b, arithmetic shift right by FRAC_BITS, added into a 32-bit wrapping accumulator.
- Step, for j = 0..N-1:
  - acc = b[j] + Σi x[i]·Wx[i][j] + Σk h[k]·Wh[k][j];
  - hn[j] = clamp(acc, -(1<<FRAC_BITS), +(1<<FRAC_BITS)).
  - COMMIT swaps the buffers (h ← hn) and increments the step count.
  - A step always reads the old h; a partially computed hn is never visible.
- Dense pass, for c = 0..C-1: result[c] = bd[c] + Σk h[k]·Wd[c][k], reduced to 16 bits per Configuration. When the pass completes, valid is set.
- States and transitions:
  - IDLE → INIT on bit0 (step), or → D_INIT on bit1 (dense).
  - INIT → MAC_X (E cycles) → MAC_H (N cycles) → ACT → INIT, or → COMMIT after the last j.
  - COMMIT → IDLE.
  - D_INIT → D_MAC (N cycles) → D_WR → D_INIT, or → IDLE after the last c.
- busy = state ≠ IDLE.
- Boundary rules:
  - CTRL writes while busy are ignored.
  - If bit0 and bit1 are written together, the step runs and the dense request is dropped.
  - bit2 in IDLE zeroes h and hn in one cycle. Combined with bit0, the clear happens first and the step runs on h = 0.
  - Starting a new dense pass clears valid and rptr.
  - Reset mid-operation aborts immediately.
- Reset values:
  - state IDLE;
  - all arrays, acc, rptr and step count 0;
  - valid 0, irq 0;
  - data_out 0.

## Timing
- A start write in cycle t makes busy=1 from cycle t+1.
- Step latency is N·(E+N+2)+1 busy cycles.
- Dense latency is C·(N+2) busy cycles.
- irq pulses in the first IDLE cycle after completion. valid is set in that same cycle.
- data_out is combinational from addr, read and registers, so it is valid in the cycle read=1.
- Register-write side effects (including CTRL and rptr) take effect at the next edge.
- Read side effects (rptr increment, valid clear) occur at the edge that ends the read cycle. A read held for k cycles advances rptr k times.

## Configuration
- RNN_SAT_EN defined: a dense result outside [-32768, 32767] saturates to 0x8000 or 0x7FFF.
- RNN_SAT_EN undefined: the result is the low 16 bits of acc (two's-complement wrap).
- Hard-tanh clamping is unaffected by the macro.

## Test plan
All scenarios use EMB_BITS=1, RNN_BITS=1, OUT_BITS=1, FRAC_BITS=8.
- Wx all 0x0100, x = {0x0080, 0x0040}, b = Wh = 0, start step → busy for exactly 13 cycles, irq once, h = {0x00C0, 0x00C0}, step count 1.
- Then Wd[0] = {0x0100, 0x0100}, bd[0] = 0x0010, Wd[1] = 0, bd[1] = 0xFFF0, start dense → 8 busy cycles, then:
  - write addr 7 with data_in[31:24] = 0;
  - read 7 → 0x00000190;
  - read 7 again → 0xFFFFFFF0 and valid = 0.
- Activation clamp: x[0] = 0x7FFF with Wx = 0x0100 → h = 0x0100; x[0] = 0x8000 → h = 0xFF00.
- Recurrence: Wh = 0x0080 diagonal, x = 0, h = 0x00C0 from scenario 1, step → h = 0x0060. CTRL = 0x5 → h cleared first, then the step yields 0.
- Saturation: h = 0x0100 both, Wd[0] = 0x7FFF both, bd[0] = 0 → result 0x7FFF with RNN_SAT_EN, 0xFFFE without.
- Robustness:
  - writes and CTRL starts during busy change nothing;
  - rst asserted mid-step → next cycle state IDLE, h = 0, busy = 0, irq = 0, data_out = 0.

Source files
------------

// File: rtl/rnn_seq_engine.sv
// rtl/rnn_seq_engine.sv - Elman RNN step engine with dense output head on a simple slave bus
// Optional feature macro: RNN_SAT_EN (saturate dense results to 16 bits instead of wrapping)
module rnn_seq_engine #(
   parameter int EMB_BITS  = 2,
   parameter int RNN_BITS  = 5,
   parameter int OUT_BITS  = 0,
   parameter int FRAC_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic [2:0]  addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        irq
);

   localparam int E  = 1 << EMB_BITS;
   localparam int N  = 1 << RNN_BITS;
   localparam int C  = 1 << OUT_BITS;
   localparam int EW = (EMB_BITS > 0) ? EMB_BITS : 1;
   localparam int NW = (RNN_BITS > 0) ? RNN_BITS : 1;
   localparam int OW = (OUT_BITS > 0) ? OUT_BITS : 1;

   // Last index of each dimension; also serves as the truncation mask (sizes are powers of two)
   localparam logic [EW-1:0] E_LAST = EW'(E - 1);
   localparam logic [NW-1:0] N_LAST = NW'(N - 1);
   localparam logic [OW-1:0] C_LAST = OW'(C - 1);

   localparam logic signed [31:0] HT_MAX = 32'sd1 <<< FRAC_BITS;
   localparam logic signed [31:0] HT_MIN = -HT_MAX;

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_MAC_X, S_MAC_H, S_ACT, S_COMMIT, S_D_INIT, S_D_MAC, S_D_WR
   } state_t;

   function automatic logic signed [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   state_t              r_state;
   logic signed [15:0]  r_x   [E];
   logic signed [15:0]  r_wx  [E][N];
   logic signed [15:0]  r_wh  [N][N];
   logic signed [15:0]  r_b   [N];
   logic signed [15:0]  r_wd  [C][N];
   logic signed [15:0]  r_bd  [C];
   logic signed [15:0]  r_h   [N];
   logic signed [15:0]  r_hn  [N];
   logic signed [15:0]  r_res [C];
   logic signed [31:0]  r_acc;
   logic [EW-1:0]       r_i;
   logic [NW-1:0]       r_k;
   logic [NW-1:0]       r_j;
   logic [OW-1:0]       r_c;
   logic [OW-1:0]       r_rptr;
   logic [15:0]         r_step_cnt;
   logic                r_valid;
   logic                r_irq;

   logic                w_busy;
   logic [EW-1:0]       w_col_e, w_row_e;
   logic [NW-1:0]       w_col_n, w_row_n;
   logic [OW-1:0]       w_row_c;
   logic signed [15:0]  w_mul_a, w_mul_b;
   logic signed [31:0]  w_full, w_prod;
   logic signed [15:0]  w_act, w_red;
   logic [31:0]         w_data_out;
   logic                w_unused;

   assign w_busy  = (r_state != S_IDLE);
   assign w_col_e = data_in[16 +: EW] & E_LAST;
   assign w_row_e = data_in[24 +: EW] & E_LAST;
   assign w_col_n = data_in[16 +: NW] & N_LAST;
   assign w_row_n = data_in[24 +: NW] & N_LAST;
   assign w_row_c = data_in[24 +: OW] & C_LAST;
   assign w_unused = ^data_in;

   // Operand select for the single shared multiplier
   always_comb begin
      w_mul_a = '0;
      w_mul_b = '0;
      case (r_state)
         S_MAC_X: begin
            w_mul_a = r_x[r_i];
            w_mul_b = r_wx[r_i][r_j];
         end
         S_MAC_H: begin
            w_mul_a = r_h[r_k];
            w_mul_b = r_wh[r_k][r_j];
         end
         S_D_MAC: begin
            w_mul_a = r_h[r_k];
            w_mul_b = r_wd[r_c][r_k];
         end
         default: ;
      endcase
   end

   assign w_full = sext16(w_mul_a) * sext16(w_mul_b);
   assign w_prod = w_full >>> FRAC_BITS;

   // Hard-tanh: clamp the accumulator to +/- one in fixed point
   always_comb begin
      w_act = r_acc[15:0];
      if (r_acc > HT_MAX)
         w_act = HT_MAX[15:0];
      else if (r_acc < HT_MIN)
         w_act = HT_MIN[15:0];
   end

   // Dense result reduction from 32-bit accumulator to 16 bits
   always_comb begin
      w_red = r_acc[15:0];
`ifdef RNN_SAT_EN
      if (r_acc > 32'sd32767)
         w_red = 16'h7FFF;
      else if (r_acc < -32'sd32768)
         w_red = 16'h8000;
`endif
   end

   // Read data mux; purely combinational so data is valid in the read cycle
   always_comb begin
      w_data_out = '0;
      if (read) begin
         case (addr)
            3'd0:    w_data_out = {30'b0, r_valid, w_busy};
            3'd1:    w_data_out = sext16(r_step_cnt);
            3'd2:    w_data_out = sext16(r_h[w_col_n]);
            3'd7:    w_data_out = sext16(r_res[r_rptr]);
            default: w_data_out = '0;
         endcase
      end
   end

   assign data_out = w_data_out;
   assign irq      = r_irq;

   // Sequencer, datapath and register file; bus writes only land while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_acc      <= '0;
         r_i        <= '0;
         r_k        <= '0;
         r_j        <= '0;
         r_c        <= '0;
         r_rptr     <= '0;
         r_step_cnt <= '0;
         r_valid    <= 1'b0;
         r_irq      <= 1'b0;
         for (int a = 0; a < E; a++) begin
            r_x[a] <= '0;
            for (int b = 0; b < N; b++) r_wx[a][b] <= '0;
         end
         for (int a = 0; a < N; a++) begin
            r_b[a]  <= '0;
            r_h[a]  <= '0;
            r_hn[a] <= '0;
            for (int b = 0; b < N; b++) r_wh[a][b] <= '0;
         end
         for (int a = 0; a < C; a++) begin
            r_bd[a]  <= '0;
            r_res[a] <= '0;
            for (int b = 0; b < N; b++) r_wd[a][b] <= '0;
         end
      end else begin
         r_irq <= 1'b0;

         // Result readout walks the channels; the last channel consumes the result set
         if (read && addr == 3'd7) begin
            r_rptr <= (r_rptr == C_LAST) ? '0 : r_rptr + 1'b1;
            if (r_rptr == C_LAST) r_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (write) begin
                  case (addr)
                     3'd0: begin
                        if (data_in[2]) begin
                           for (int a = 0; a < N; a++) begin
                              r_h[a]  <= '0;
                              r_hn[a] <= '0;
                           end
                        end
                        if (data_in[0]) begin
                           r_j     <= '0;
                           r_state <= S_INIT;
                        end else if (data_in[1]) begin
                           r_c     <= '0;
                           r_valid <= 1'b0;
                           r_rptr  <= '0;
                           r_state <= S_D_INIT;
                        end
                     end
                     3'd1: r_x[w_col_e]           <= data_in[15:0];
                     3'd2: r_wx[w_row_e][w_col_n] <= data_in[15:0];
                     3'd3: r_wh[w_row_n][w_col_n] <= data_in[15:0];
                     3'd4: r_b[w_col_n]           <= data_in[15:0];
                     3'd5: r_wd[w_row_c][w_col_n] <= data_in[15:0];
                     3'd6: r_bd[w_row_c]          <= data_in[15:0];
                     3'd7: r_rptr                 <= w_row_c;
                     default: ;
                  endcase
               end
            end
            S_INIT: begin
               r_acc   <= sext16(r_b[r_j]);
               r_i     <= '0;
               r_state <= S_MAC_X;
            end
            S_MAC_X: begin
               r_acc <= r_acc + w_prod;
               if (r_i == E_LAST) begin
                  r_k     <= '0;
                  r_state <= S_MAC_H;
               end else begin
                  r_i <= r_i + 1'b1;
               end
            end
            S_MAC_H: begin
               r_acc <= r_acc + w_prod;
               if (r_k == N_LAST)
                  r_state <= S_ACT;
               else
                  r_k <= r_k + 1'b1;
            end
            S_ACT: begin
               r_hn[r_j] <= w_act;
               if (r_j == N_LAST) begin
                  r_state <= S_COMMIT;
               end else begin
                  r_j     <= r_j + 1'b1;
                  r_state <= S_INIT;
               end
            end
            S_COMMIT: begin
               for (int a = 0; a < N; a++) r_h[a] <= r_hn[a];
               r_step_cnt <= r_step_cnt + 16'd1;
               r_irq      <= 1'b1;
               r_state    <= S_IDLE;
            end
            S_D_INIT: begin
               r_acc   <= sext16(r_bd[r_c]);
               r_k     <= '0;
               r_state <= S_D_MAC;
            end
            S_D_MAC: begin
               r_acc <= r_acc + w_prod;
               if (r_k == N_LAST)
                  r_state <= S_D_WR;
               else
                  r_k <= r_k + 1'b1;
            end
            S_D_WR: begin
               r_res[r_c] <= w_red;
               if (r_c == C_LAST) begin
                  r_valid <= 1'b1;
                  r_irq   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_c     <= r_c + 1'b1;
                  r_state <= S_D_INIT;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rnn_seq_engine.sv
// tb/tb_rnn_seq_engine.sv - directed self-checking bench for rnn_seq_engine (E=2, N=2, C=2)
module tb_rnn_seq_engine;

   logic        clk;
   logic        rst;
   logic        read;
   logic        write;
   logic [2:0]  addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

`ifdef RNN_SAT_EN
   localparam logic [31:0] SAT_EXP = 32'h0000_7FFF;
`else
   localparam logic [31:0] SAT_EXP = 32'hFFFF_FFFE;
`endif

   rnn_seq_engine #(
      .EMB_BITS (1),
      .RNN_BITS (1),
      .OUT_BITS (1),
      .FRAC_BITS(8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .read    (read),
      .write   (write),
      .addr    (addr),
      .data_in (data_in),
      .data_out(data_out),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] row, input logic [7:0] col,
                            input logic [15:0] val);
      @(negedge clk);
      write   = 1'b1;
      addr    = a;
      data_in = {row, col, val};
      @(negedge clk);
      write   = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [7:0] col, output logic [31:0] v);
      @(negedge clk);
      read    = 1'b1;
      addr    = a;
      data_in = {8'h00, col, 16'h0000};
      #1;
      v = data_out;
      @(negedge clk);
      read = 1'b0;
   endtask

   // Polls STATUS from the current negedge until idle; st is STATUS in the first idle cycle
   task automatic wait_idle(output int nbusy, output int nirq, output logic [31:0] st);
      int guard;
      guard = 0;
      nbusy = 0;
      nirq  = 0;
      read  = 1'b1;
      addr  = 3'd0;
      #1;
      while (data_out[0] && guard < 2000) begin
         nbusy++;
         if (irq) nirq++;
         @(negedge clk);
         #1;
         guard++;
      end
      st = data_out;
      if (irq) nirq++;
      @(negedge clk);
      #1;
      if (irq) nirq++;
      read = 1'b0;
      chk("idle_timeout", 32'(guard < 2000), 32'd1);
   endtask

   task automatic run_ctrl(input logic [15:0] v, output int nbusy, output int nirq,
                           output logic [31:0] st);
      bus_write(3'd0, 8'd0, 8'd0, v);
      wait_idle(nbusy, nirq, st);
   endtask

   task automatic chk_h(input string tag, input logic [31:0] e0, input logic [31:0] e1);
      logic [31:0] v;
      bus_read(3'd2, 8'd0, v);
      chk({tag, "_h0"}, v, e0);
      bus_read(3'd2, 8'd1, v);
      chk({tag, "_h1"}, v, e1);
   endtask

   initial begin
      int          nb, ni;
      logic [31:0] st, v;

      rst = 1'b1; read = 1'b0; write = 1'b0; addr = 3'd0; data_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      #1;
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_dout_noread", data_out, 32'd0);
      bus_read(3'd0, 8'd0, v); chk("rst_status", v, 32'd0);
      bus_read(3'd1, 8'd0, v); chk("rst_stepcnt", v, 32'd0);
      bus_read(3'd7, 8'd0, v); chk("rst_result", v, 32'd0);
      chk_h("rst", 32'd0, 32'd0);

      // Basic step: h = Wx * x
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            bus_write(3'd2, 8'(i), 8'(j), 16'h0100);
      bus_write(3'd1, 8'd0, 8'd0, 16'h0080);
      bus_write(3'd1, 8'd0, 8'd1, 16'h0040);
      run_ctrl(16'h0001, nb, ni, st);
      chk("s1_busy", 32'(nb), 32'd13);
      chk("s1_irq", 32'(ni), 32'd1);
      chk("s1_status", st, 32'd0);
      chk_h("s1", 32'h0000_00C0, 32'h0000_00C0);
      bus_read(3'd1, 8'd0, v); chk("s1_stepcnt", v, 32'd1);

      // Dense pass and result readout
      bus_write(3'd5, 8'd0, 8'd0, 16'h0100);
      bus_write(3'd5, 8'd0, 8'd1, 16'h0100);
      bus_write(3'd6, 8'd0, 8'd0, 16'h0010);
      bus_write(3'd6, 8'd1, 8'd0, 16'hFFF0);
      run_ctrl(16'h0002, nb, ni, st);
      chk("d_busy", 32'(nb), 32'd8);
      chk("d_irq", 32'(ni), 32'd1);
      chk("d_status_valid", st, 32'd2);
      bus_write(3'd7, 8'd0, 8'd0, 16'h0000);
      bus_read(3'd7, 8'd0, v); chk("d_res0", v, 32'h0000_0190);
      bus_read(3'd0, 8'd0, v); chk("d_valid_kept", v, 32'd2);
      bus_read(3'd7, 8'd0, v); chk("d_res1", v, 32'hFFFF_FFF0);
      bus_read(3'd0, 8'd0, v); chk("d_valid_clr", v, 32'd0);

      // Recurrence through Wh, then clear combined with a step
      bus_write(3'd1, 8'd0, 8'd0, 16'h0000);
      bus_write(3'd1, 8'd0, 8'd1, 16'h0000);
      bus_write(3'd3, 8'd0, 8'd0, 16'h0080);
      bus_write(3'd3, 8'd1, 8'd1, 16'h0080);
      run_ctrl(16'h0001, nb, ni, st);
      chk_h("rec", 32'h0000_0060, 32'h0000_0060);
      run_ctrl(16'h0005, nb, ni, st);
      chk("clr_busy", 32'(nb), 32'd13);
      chk_h("clr", 32'd0, 32'd0);

      // Hard-tanh clamp both directions
      bus_write(3'd3, 8'd0, 8'd0, 16'h0000);
      bus_write(3'd3, 8'd1, 8'd1, 16'h0000);
      bus_write(3'd1, 8'd0, 8'd0, 16'h7FFF);
      run_ctrl(16'h0001, nb, ni, st);
      chk_h("clamp_pos", 32'h0000_0100, 32'h0000_0100);
      bus_write(3'd1, 8'd0, 8'd0, 16'h8000);
      run_ctrl(16'h0001, nb, ni, st);
      chk_h("clamp_neg", 32'hFFFF_FF00, 32'hFFFF_FF00);
      bus_write(3'd1, 8'd0, 8'd0, 16'h7FFF);
      run_ctrl(16'h0001, nb, ni, st);

      // Dense overflow: saturate or wrap depending on build; readout wraps mod C
      bus_write(3'd5, 8'd0, 8'd0, 16'h7FFF);
      bus_write(3'd5, 8'd0, 8'd1, 16'h7FFF);
      bus_write(3'd6, 8'd0, 8'd0, 16'h0000);
      run_ctrl(16'h0002, nb, ni, st);
      bus_write(3'd7, 8'd0, 8'd0, 16'h0000);
      bus_read(3'd7, 8'd0, v); chk("sat_res0", v, SAT_EXP);
      bus_read(3'd7, 8'd0, v); chk("sat_res1", v, 32'hFFFF_FFF0);
      bus_read(3'd7, 8'd0, v); chk("rptr_wrap", v, SAT_EXP);

      // Writes and CTRL starts while busy are ignored (rptr is now 1)
      bus_write(3'd0, 8'd0, 8'd0, 16'h0001);
      bus_write(3'd1, 8'd0, 8'd0, 16'h0010);
      bus_write(3'd2, 8'd0, 8'd1, 16'h0000);
      bus_write(3'd0, 8'd0, 8'd0, 16'h0006);
      bus_write(3'd7, 8'd0, 8'd0, 16'h0000);
      wait_idle(nb, ni, st);
      chk("rob_busy_rest", 32'(nb), 32'd5);
      chk("rob_status", st, 32'd0);
      chk_h("rob", 32'h0000_0100, 32'h0000_0100);
      bus_read(3'd1, 8'd0, v); chk("rob_stepcnt", v, 32'd7);
      bus_read(3'd7, 8'd0, v); chk("rob_rptr", v, 32'hFFFF_FFF0);

      // Reset mid-step aborts at once
      bus_write(3'd0, 8'd0, 8'd0, 16'h0001);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("arst_irq", 32'(irq), 32'd0);
      chk("arst_dout", data_out, 32'd0);
      read = 1'b1; addr = 3'd0; #1;
      chk("arst_status", data_out, 32'd0);
      read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk_h("arst", 32'd0, 32'd0);
      bus_read(3'd1, 8'd0, v); chk("arst_stepcnt", v, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
